// File: rtl/interleaver_pkg.sv
// ---------------------------------------------------------------------------
// interleaver_pkg
// Shared definitions for the turbo-code interleaver bank scheduler:
//   - bank_state_t : per-bank lifecycle (EMPTY -> FILLING -> FULL -> DRAINING)
//   - SMALL_K / LARGE_K : the two supported block lengths in bits
//   - k_of()       : block length selected by a latched blocksize bit
// ---------------------------------------------------------------------------
package interleaver_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    localparam int unsigned SMALL_K = 1056;
    localparam int unsigned LARGE_K = 6144;

    // blocksize 1 selects the large block, 0 the small one
    function automatic int unsigned k_of(input logic blocksize);
        return blocksize ? LARGE_K : SMALL_K;
    endfunction

endpackage

// File: rtl/interleaver_bank_tracker.sv
// ---------------------------------------------------------------------------
// interleaver_bank_tracker
// Lifecycle state and latched blocksize of one interleaver RAM bank.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   fill_open         : writer claims this (EMPTY) bank; latches start_blocksize
//   start_blocksize   : blocksize presented with fill_open
//   fill_done         : last bit of the block written
//   drain_open        : reader takes this FULL bank
//   drain_done        : last bit of the block read
//   state             : current bank state
//   blocksize         : latched blocksize of the block held in the bank
// ---------------------------------------------------------------------------
module interleaver_bank_tracker
    import interleaver_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        fill_open,
    input  logic        start_blocksize,
    input  logic        fill_done,
    input  logic        drain_open,
    input  logic        drain_done,
    output bank_state_t state,
    output logic        blocksize
);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            blocksize <= 1'b0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (fill_open) begin
                        state     <= FILLING;
                        blocksize <= start_blocksize;
                    end
                end
                FILLING:  if (fill_done)  state <= FULL;
                FULL:     if (drain_open) state <= DRAINING;
                DRAINING: if (drain_done) state <= EMPTY;
                default:  state <= EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/interleaver_bank_scheduler.sv
// ---------------------------------------------------------------------------
// interleaver_bank_scheduler
// Ping-pong scheduler for the two interleaver RAM banks. The CRC-side writer
// fills one bank while the encoder-side reader drains the other; blocks are
// drained strictly in fill order. Linear indices only (pi applied outside).
// Optional feature macro: INTERLEAVER_SCHED_ERR_EN (sticky err_overflow).
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   wr_start         : open a block (accepted only when wr_start_ready)
//   wr_blocksize     : 0 = SMALL_K, 1 = LARGE_K; sampled with wr_start
//   wr_valid         : one input bit this cycle
//   wr_start_ready   : bank under wr_ptr is EMPTY
//   wr_ready         : bank under wr_ptr is FILLING
//   wr_we/wr_bank/wr_idx : RAM write strobe, bank and linear index
//   rd_ready         : downstream requests one bit
//   rd_en/rd_bank/rd_idx : RAM read strobe, bank and linear index
//   rd_blocksize     : latched blocksize of the bank under rd_ptr
//   rd_valid/rd_last : read data valid (rd_en delayed RD_LAT) and last bit
//   err_overflow     : sticky protocol error (0 unless macro defined)
// ---------------------------------------------------------------------------
module interleaver_bank_scheduler #(
    parameter int unsigned SMALL_K = 1056,
    parameter int unsigned LARGE_K = 6144,
    parameter int unsigned AW      = 13,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_start,
    input  logic          wr_blocksize,
    input  logic          wr_valid,
    output logic          wr_start_ready,
    output logic          wr_ready,
    output logic          wr_we,
    output logic          wr_bank,
    output logic [AW-1:0] wr_idx,
    input  logic          rd_ready,
    output logic          rd_en,
    output logic          rd_bank,
    output logic [AW-1:0] rd_idx,
    output logic          rd_blocksize,
    output logic          rd_valid,
    output logic          rd_last,
    output logic          err_overflow
);
    import interleaver_pkg::*;

    localparam logic [AW-1:0] SMALL_LAST = AW'(SMALL_K - 1);
    localparam logic [AW-1:0] LARGE_LAST = AW'(LARGE_K - 1);

    bank_state_t       state [2];
    logic [1:0]        bank_bs;
    logic              wr_ptr;
    logic              rd_ptr;
    logic              start_ok;
    logic              wr_end;
    logic              rd_end;
    logic [1:0]        fill_open;
    logic [1:0]        fill_done;
    logic [1:0]        drain_open;
    logic [1:0]        drain_done;
    logic [RD_LAT-1:0] valid_pipe;
    logic [RD_LAT-1:0] last_pipe;

    always_comb begin
        wr_start_ready = (state[wr_ptr] == EMPTY);
        wr_ready       = (state[wr_ptr] == FILLING);
        wr_we          = wr_valid & wr_ready;
        rd_en          = (state[rd_ptr] == DRAINING) & rd_ready;
        start_ok       = wr_start & wr_start_ready;
        wr_end         = wr_we & (wr_idx == (bank_bs[wr_ptr] ? LARGE_LAST : SMALL_LAST));
        rd_end         = rd_en & (rd_idx == (bank_bs[rd_ptr] ? LARGE_LAST : SMALL_LAST));
        fill_open      = {start_ok & wr_ptr, start_ok & ~wr_ptr};
        fill_done      = {wr_end & wr_ptr, wr_end & ~wr_ptr};
        // a FULL bank is only handed to the reader when rd_ptr reaches it,
        // which keeps drain order identical to fill order
        drain_open     = {rd_ptr & (state[1] == FULL), ~rd_ptr & (state[0] == FULL)};
        drain_done     = {rd_end & rd_ptr, rd_end & ~rd_ptr};
    end

    assign wr_bank      = wr_ptr;
    assign rd_bank      = rd_ptr;
    assign rd_blocksize = bank_bs[rd_ptr];
    assign rd_valid     = valid_pipe[RD_LAT-1];
    assign rd_last      = last_pipe[RD_LAT-1];

    interleaver_bank_tracker u_bank0 (
        .clk             (clk),
        .reset           (reset),
        .fill_open       (fill_open[0]),
        .start_blocksize (wr_blocksize),
        .fill_done       (fill_done[0]),
        .drain_open      (drain_open[0]),
        .drain_done      (drain_done[0]),
        .state           (state[0]),
        .blocksize       (bank_bs[0])
    );

    interleaver_bank_tracker u_bank1 (
        .clk             (clk),
        .reset           (reset),
        .fill_open       (fill_open[1]),
        .start_blocksize (wr_blocksize),
        .fill_done       (fill_done[1]),
        .drain_open      (drain_open[1]),
        .drain_done      (drain_done[1]),
        .state           (state[1]),
        .blocksize       (bank_bs[1])
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            wr_idx <= '0;
            rd_idx <= '0;
        end else begin
            if (start_ok) begin
                wr_idx <= '0;
            end else if (wr_we) begin
                wr_idx <= wr_end ? '0 : wr_idx + AW'(1);
            end
            if (wr_end) wr_ptr <= ~wr_ptr;

            if (|drain_open) begin
                rd_idx <= '0;
            end else if (rd_en) begin
                rd_idx <= rd_end ? '0 : rd_idx + AW'(1);
            end
            if (rd_end) rd_ptr <= ~rd_ptr;
        end
    end

    // read-data valid/last pipeline; the one-stage case avoids a negative slice
    if (RD_LAT == 1) begin : g_lat1
        always_ff @(posedge clk) begin
            if (reset) begin
                valid_pipe <= '0;
                last_pipe  <= '0;
            end else begin
                valid_pipe <= rd_en;
                last_pipe  <= rd_end;
            end
        end
    end else begin : g_latn
        always_ff @(posedge clk) begin
            if (reset) begin
                valid_pipe <= '0;
                last_pipe  <= '0;
            end else begin
                valid_pipe <= {valid_pipe[RD_LAT-2:0], rd_en};
                last_pipe  <= {last_pipe[RD_LAT-2:0], rd_end};
            end
        end
    end

`ifdef INTERLEAVER_SCHED_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_overflow <= 1'b0;
        end else if ((wr_start & ~wr_start_ready) | (wr_valid & ~wr_ready)) begin
            err_overflow <= 1'b1;
        end
    end
`else
    assign err_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_interleaver_bank_scheduler.sv
// ---------------------------------------------------------------------------
// tb_interleaver_bank_scheduler
// Directed bench for interleaver_bank_scheduler: a short table of per-cycle
// vectors for reset and block opening, then hand-written multi-cycle
// sequences (single block, ping-pong, both banks full, drain/start
// collision, reset mid-operation). A small write/read order model checks
// every write index, every read index/bank/blocksize and rd_last placement.
// ---------------------------------------------------------------------------
module tb_interleaver_bank_scheduler;
    import interleaver_pkg::*;

    localparam int unsigned AW = 13;

    logic          clk;
    logic          reset;
    logic          wr_start;
    logic          wr_blocksize;
    logic          wr_valid;
    logic          wr_start_ready;
    logic          wr_ready;
    logic          wr_we;
    logic          wr_bank;
    logic [AW-1:0] wr_idx;
    logic          rd_ready;
    logic          rd_en;
    logic          rd_bank;
    logic [AW-1:0] rd_idx;
    logic          rd_blocksize;
    logic          rd_valid;
    logic          rd_last;
    logic          err_overflow;

    interleaver_bank_scheduler #(
        .SMALL_K (1056),
        .LARGE_K (6144),
        .AW      (AW),
        .RD_LAT  (1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .wr_start       (wr_start),
        .wr_blocksize   (wr_blocksize),
        .wr_valid       (wr_valid),
        .wr_start_ready (wr_start_ready),
        .wr_ready       (wr_ready),
        .wr_we          (wr_we),
        .wr_bank        (wr_bank),
        .wr_idx         (wr_idx),
        .rd_ready       (rd_ready),
        .rd_en          (rd_en),
        .rd_bank        (rd_bank),
        .rd_idx         (rd_idx),
        .rd_blocksize   (rd_blocksize),
        .rd_valid       (rd_valid),
        .rd_last        (rd_last),
        .err_overflow   (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        bs;
        logic        valid;
        logic        rdy;
        logic        sr;
        logic        wrdy;
        logic        we;
        int unsigned widx;
        logic        rden;
        logic        rvalid;
    } vec_t;

    vec_t tbl [7];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // write/read order model
    bit          exp_filling;
    bit          exp_start_ok;
    bit          exp_wr_bank;
    bit          exp_rd_bank;
    bit          cur_bs;
    int unsigned exp_wr_idx;
    int unsigned exp_rd_idx;
    int unsigned vcount;
    int unsigned n_valid;
    int unsigned n_overlap;
    bit          rd_q [$];
    bit          v_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // One clock: inputs already driven at the negedge; check, then advance.
    task automatic step();
        bit take;
        take = 1'b0;
        #1;
        if (!reset) begin
            chk("wr_ready", wr_ready, exp_filling);
            chk("wr_we", wr_we, wr_valid & exp_filling);
            if (wr_valid && exp_filling) begin
                chk("wr_idx", wr_idx, exp_wr_idx);
                chk("wr_bank", wr_bank, exp_wr_bank);
                if (exp_wr_idx == k_of(cur_bs) - 1) begin
                    exp_filling = 1'b0;
                    exp_wr_idx  = 0;
                    exp_wr_bank = ~exp_wr_bank;
                    rd_q.push_back(cur_bs);
                    v_q.push_back(cur_bs);
                end else begin
                    exp_wr_idx++;
                end
            end
            if (wr_start) begin
                chk("wr_start_ready", wr_start_ready, exp_start_ok);
                take = exp_start_ok;
            end
            if (!rd_ready) chk("rd_en_gated", rd_en, 0);
            if (rd_en) begin
                if (rd_q.size() == 0) begin
                    chk("rd_en_spurious", rd_en, 0);
                end else begin
                    chk("rd_bank", rd_bank, exp_rd_bank);
                    chk("rd_idx", rd_idx, exp_rd_idx);
                    chk("rd_blocksize", rd_blocksize, rd_q[0]);
                    if (wr_we) n_overlap++;
                    if (exp_rd_idx == k_of(rd_q[0]) - 1) begin
                        void'(rd_q.pop_front());
                        exp_rd_idx  = 0;
                        exp_rd_bank = ~exp_rd_bank;
                    end else begin
                        exp_rd_idx++;
                    end
                end
            end
            if (rd_valid) begin
                if (v_q.size() == 0) begin
                    chk("rd_valid_spurious", rd_valid, 0);
                end else begin
                    n_valid++;
                    vcount++;
                    chk("rd_last", rd_last, vcount == k_of(v_q[0]));
                    if (vcount == k_of(v_q[0])) begin
                        void'(v_q.pop_front());
                        vcount = 0;
                    end
                end
            end else begin
                chk("rd_last_idle", rd_last, 0);
            end
        end
        @(posedge clk);
        if (take) begin
            exp_filling = 1'b1;
            exp_wr_idx  = 0;
            cur_bs      = wr_blocksize;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        wr_start     = 1'b0;
        wr_blocksize = 1'b0;
        wr_valid     = 1'b0;
        exp_start_ok = 1'b0;
        step();
        reset        = 1'b0;
        exp_filling  = 1'b0;
        exp_wr_bank  = 1'b0;
        exp_rd_bank  = 1'b0;
        exp_wr_idx   = 0;
        exp_rd_idx   = 0;
        vcount       = 0;
        n_valid      = 0;
        n_overlap    = 0;
        rd_q.delete();
        v_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        #1;
        chk({tag, "_start_ready"}, wr_start_ready, 1);
        chk({tag, "_wr_ready"}, wr_ready, 0);
        chk({tag, "_wr_we"}, wr_we, 0);
        chk({tag, "_wr_bank"}, wr_bank, 0);
        chk({tag, "_wr_idx"}, wr_idx, 0);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_rd_bank"}, rd_bank, 0);
        chk({tag, "_rd_idx"}, rd_idx, 0);
        chk({tag, "_rd_blocksize"}, rd_blocksize, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_last"}, rd_last, 0);
        chk({tag, "_err"}, err_overflow, 0);
    endtask

    task automatic start_block(input logic bs, input bit ok);
        wr_start     = 1'b1;
        wr_blocksize = bs;
        exp_start_ok = ok;
        step();
        wr_start     = 1'b0;
        wr_blocksize = 1'b0;
    endtask

    task automatic fill_rest();
        wr_valid = 1'b1;
        for (int i = 0; i < 7000 && exp_filling; i++) step();
        wr_valid = 1'b0;
    endtask

    task automatic drain_all(input string tag, input int unsigned bound);
        for (int unsigned i = 0; i < bound && (rd_q.size() != 0 || v_q.size() != 0); i++) step();
        chk({tag, "_drain_complete"}, rd_q.size() + v_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // start bs valid rdy | sr wrdy we widx rden rvalid
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b0};

        reset = 1'b0; wr_start = 1'b0; wr_blocksize = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        exp_start_ok = 1'b0;
        @(negedge clk);

        // reset defaults
        do_reset();
        check_idle_outputs("rst");

        // single small block: opening cycles from the table
        for (int i = 0; i < 7; i++) begin
            wr_start     = tbl[i].start;
            wr_blocksize = tbl[i].bs;
            wr_valid     = tbl[i].valid;
            rd_ready     = tbl[i].rdy;
            exp_start_ok = tbl[i].sr;
            #1;
            chk($sformatf("vec%0d_start_ready", i), wr_start_ready, tbl[i].sr);
            chk($sformatf("vec%0d_wr_ready", i), wr_ready, tbl[i].wrdy);
            chk($sformatf("vec%0d_wr_we", i), wr_we, tbl[i].we);
            chk($sformatf("vec%0d_wr_idx", i), wr_idx, tbl[i].widx);
            chk($sformatf("vec%0d_rd_en", i), rd_en, tbl[i].rden);
            chk($sformatf("vec%0d_rd_valid", i), rd_valid, tbl[i].rvalid);
            step();
        end
        wr_start = 1'b0;
        fill_rest();
        #1;
        chk("small_n1_rd_en", rd_en, 0);
        chk("small_n1_start_ready", wr_start_ready, 1);
        chk("small_n1_wr_bank", wr_bank, 1);
        step();
        #1;
        chk("small_first_rd_en", rd_en, 1);
        chk("small_first_rd_bank", rd_bank, 0);
        drain_all("small", 3000);
        chk("small_valid_count", n_valid, 1056);
        #1;
        chk("small_after_rd_en", rd_en, 0);
        chk("small_after_rd_bank", rd_bank, 1);

        // ping-pong: large then small, back to back
        do_reset();
        rd_ready = 1'b1;
        start_block(1'b1, 1'b1);
        fill_rest();
        start_block(1'b0, 1'b1);
        fill_rest();
        drain_all("pingpong", 14000);
        chk("pingpong_valid_count", n_valid, 6144 + 1056);
        chk("pingpong_overlap", n_overlap != 0, 1);

        // both banks full with reader stalled
        do_reset();
        rd_ready = 1'b0;
        start_block(1'b0, 1'b1);
        fill_rest();
        start_block(1'b0, 1'b1);
        fill_rest();
        step();
        step();
        start_block(1'b1, 1'b0);
        #1;
`ifdef INTERLEAVER_SCHED_ERR_EN
        chk("full_err_overflow", err_overflow, 1);
`else
        chk("full_err_overflow", err_overflow, 0);
`endif
        chk("full_wr_ready", wr_ready, 0);

        // drain/start collision on the last read of bank 0
        rd_ready = 1'b1;
        repeat (1055) step();
        wr_start     = 1'b1;
        wr_blocksize = 1'b1;
        exp_start_ok = 1'b0;
        #1;
        chk("collide_rd_en", rd_en, 1);
        chk("collide_rd_idx", rd_idx, 1055);
        step();
        exp_start_ok = 1'b1;
        step();
        wr_start = 1'b0;
        fill_rest();
        drain_all("collide", 16000);
        chk("collide_valid_count", n_valid, 1056 * 2 + 6144);

        // reset in the middle of a fill on bank 1 and a drain on bank 0
        do_reset();
        rd_ready = 1'b1;
        start_block(1'b1, 1'b1);
        fill_rest();
        start_block(1'b0, 1'b1);
        wr_valid = 1'b1;
        repeat (100) step();
        #1;
        chk("midrst_pre_rd_en", rd_en, 1);
        chk("midrst_pre_wr_bank", wr_bank, 1);
        do_reset();
        check_idle_outputs("midrst");
        repeat (5) step();
        chk("midrst_no_valid", n_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
